pipe_datapath: RTL and testbench
================================

PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 Parameter DW, default 8, data and register width in bits (8..32).
REQ-002 Parameter AW, default 8, PC and data-address width in bits (AW <= 8).
REQ-003 Parameter PC_INC, default 4, sequential PC increment.
REQ-004 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1; reset is asynchronous and active-high.
REQ-006 Port Instr, input, 16, instruction fetched at address PC, valid in the same cycle.
REQ-007 Port RegWrite, MemWrite, ALUSrc, ImmSrc, LM, PCSrc, input, 1 each, decoded controls accompanying Instr.
REQ-008 Port ALUControl, input, 5, ALU opcode accompanying Instr.
REQ-009 Port Stall, input, 1, external hold request.
REQ-010 Port ReadData, input, DW, data memory read value, combinational in the cycle DataAdr is driven.
REQ-011 Port PC, output, AW, fetch address.
REQ-012 Port DataAdr, output, AW, data memory address from the E stage.
REQ-013 Port WriteData, output, DW, store data from the E stage.
REQ-014 Port MemWriteOut, output, 1, store strobe, equal to MemWrite AND E-valid AND NOT Stall.
REQ-015 Port ALUFlags, output, 4, {N,Z,C,V} of the current E-stage ALU result.
REQ-016 Port Retired, output, 16, count of instructions that completed write-back.

Function
REQ-017 Three stages: F (PC register), E (register F/E: instruction, controls, valid), W (register E/W: rd, result, we, valid).
REQ-018 Field map: rd = Instr[10:8], rs1 = Instr[5:3], rs2 = Instr[2:0], target = Instr[AW-1:0]; 8 registers, all writable.
REQ-019 ExtImm: ImmSrc=0 zero-extends Instr[2:0] to DW; ImmSrc=1 sign-extends Instr[7:0] to DW.
REQ-020 SrcA = rs1 operand; SrcB = ExtImm when ALUSrc=1, else the rs2 operand; WriteData = the rs2 operand.
REQ-021 ALU ops: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL by B[2:0], 6 SHR logical by B[2:0], 7 PASS B; all other codes give result 0 with flags computed on 0.
REQ-022 C = carry-out for ADD and not-borrow for SUB, 0 otherwise; V = two's-complement overflow for ADD/SUB, 0 otherwise; results truncate to DW.
REQ-023 DataAdr = SrcA[AW-1:0] + Instr[7:0] (mod 2^AW) when LM or MemWrite is set, else 0.
REQ-024 W result = ReadData when LM, else the ALU result; the register write occurs on the edge that retires W when its we and valid bits are both 1.
REQ-025 Forwarding: an E operand read whose index equals W.rd with W we and valid set takes the W result; otherwise it takes the register-file value.
REQ-026 Back-to-back dependent instructions, including load-use, execute with no stall and give the architecturally correct value.
REQ-027 PC: the next PC is target when E holds a valid instruction with PCSrc=1; otherwise PC + PC_INC (mod 2^AW).
REQ-028 Taken branch: the F/E register loads a bubble (valid=0) on the same edge; penalty is exactly 1 cycle; the branch itself retires if RegWrite is set.
REQ-029 Stall=1: PC and F/E hold; the E/W register loads a bubble; Retired does not increment from the bubble; MemWriteOut=0.
REQ-030 Stall has priority over a branch: a held branch resolves on the first cycle with Stall=0.
REQ-031 Retired increments by 1 per valid W retirement and wraps 0xFFFF -> 0x0000.

Reset
REQ-032 Asserting reset immediately clears PC=0, F/E and E/W valid=0, all registers=0, and Retired=0.
REQ-033 Reset mid-operation discards in-flight instructions with no register write and no store strobe; MemWriteOut=0 and DataAdr=0 while reset is asserted.
REQ-034 The first fetch after deassertion is at address 0, and the first instruction reaches E on the following edge.

Structure
REQ-035 Shared package pipe_pkg holds the ALU opcode constants, flag bit indices, and field-position constants.
REQ-036 The ALU is the single sub-module pipe_alu, parametrised by DW; the register file, forwarding, and hazard logic stay inline.

Verification
REQ-037 Verify a straight-line program: ADD r1=r0+imm 3, then ADD r2=r1+r1 -> r2=6, Retired=2, with no stall cycles.
REQ-038 Verify load-use: LM r3 from address 0x10 with ReadData=0xA5, then ADD r4=r3+r0 next cycle -> r4=0xA5.
REQ-039 Verify a taken branch to 0x40: the next PC is 0x40, the instruction fetched after the branch never retires, and Retired counts only the branch.
REQ-040 Verify Stall held 3 cycles during a branch in E: PC frozen, MemWriteOut=0, then PC=target on the first cycle after Stall deasserts.
REQ-041 Verify the ALU at DW=16: SUB 0x8000-1 -> 0x7FFF with V=1 and C=1; ADD 0xFFFF+1 -> 0 with Z=1 and C=1; opcode 9 -> result 0.
REQ-042 Verify reset asserted mid-pipeline with a store in E: MemWriteOut falls immediately, all registers=0, and PC=0 after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the three-stage datapath.
//   - ALU opcode constants (5-bit ALUControl encoding)
//   - ALUFlags bit indices ({N,Z,C,V})
//   - instruction field positions and widths
//   - fe_t: the F/E pipeline register bundle (instruction, controls, valid)
package pipe_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SHL  = 5'd5;
  localparam logic [4:0] ALU_SHR  = 5'd6;
  localparam logic [4:0] ALU_PASS = 5'd7;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int REG_COUNT = 8;
  localparam int REG_IDX_W = 3;
  localparam int RD_LSB    = 8;
  localparam int RS1_LSB   = 3;
  localparam int RS2_LSB   = 0;
  localparam int IMM_S_W   = 8;  // sign-extended immediate Instr[7:0]
  localparam int IMM_Z_W   = 3;  // zero-extended immediate Instr[2:0]
  localparam int OFS_W     = 8;  // memory offset Instr[7:0]

  typedef struct packed {
    logic [15:0] instr;
    logic        regwrite;
    logic        memwrite;
    logic        alusrc;
    logic        immsrc;
    logic        lm;
    logic        pcsrc;
    logic [4:0]  aluctl;
    logic        valid;
  } fe_t;

endpackage

// File: rtl/pipe_alu.sv
// Combinational ALU for the E stage.
// Ports:
//   a, b   : operands (DW bits)
//   op     : 5-bit opcode; unknown codes yield a zero result
//   result : DW-bit result, truncated
//   flags  : {N,Z,C,V}; C is carry for ADD and not-borrow for SUB,
//            V is signed overflow for ADD/SUB; both are 0 for other ops
module pipe_alu
  import pipe_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [4:0]    op,
  output logic [DW-1:0] result,
  output logic [3:0]    flags
);

  logic [DW:0] sum;
  logic        c;
  logic        v;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        // a + ~b + 1: the carry out is the not-borrow flag
        sum    = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
        result = sum[DW-1:0];
        c      = sum[DW];
        v      = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SHL:  result = a << b[2:0];
      ALU_SHR:  result = a >> b[2:0];
      ALU_PASS: result = b;
      default:  result = '0;
    endcase
    flags         = '0;
    flags[FLAG_N] = result[DW-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/pipe_datapath.sv
// Three-stage (F / E / W) datapath with W->E forwarding.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   Instr + controls: instruction at PC and its decoded controls (same cycle)
//   Stall           : hold request; PC and F/E hold, E/W takes a bubble
//   ReadData        : data memory read value for DataAdr (combinational)
//   PC              : fetch address
//   DataAdr         : E-stage memory address (0 unless LM or MemWrite)
//   WriteData       : E-stage store data (rs2 operand)
//   MemWriteOut     : store strobe
//   ALUFlags        : {N,Z,C,V} of the E-stage ALU result
//   Retired         : count of instructions leaving W (wraps)
// Pipeline qualification: each stage register carries a valid bit; a stage
// acts only when its valid bit is 1, and Stall overrides every advance.
module pipe_datapath
  import pipe_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int PC_INC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   Instr,
  input  logic          RegWrite,
  input  logic          MemWrite,
  input  logic          ALUSrc,
  input  logic          ImmSrc,
  input  logic          LM,
  input  logic          PCSrc,
  input  logic [4:0]    ALUControl,
  input  logic          Stall,
  input  logic [DW-1:0] ReadData,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] DataAdr,
  output logic [DW-1:0] WriteData,
  output logic          MemWriteOut,
  output logic [3:0]    ALUFlags,
  output logic [15:0]   Retired
);

  fe_t                 fe_q;
  fe_t                 fe_d;
  logic [DW-1:0]       rf [REG_COUNT];
  logic [REG_IDX_W-1:0] w_rd;
  logic [DW-1:0]       w_res;
  logic                w_we;
  logic                w_valid;

  logic [REG_IDX_W-1:0] e_rd;
  logic [REG_IDX_W-1:0] e_rs1;
  logic [REG_IDX_W-1:0] e_rs2;
  logic [DW-1:0]       ext_imm;
  logic [DW-1:0]       src_a;
  logic [DW-1:0]       src_b;
  logic [DW-1:0]       rs2_val;
  logic [DW-1:0]       alu_res;
  logic [DW-1:0]       e_res;
  logic                e_branch;
  logic                e_mem;
  logic                unused_hi;

  always_comb begin
    fe_d          = '0;
    fe_d.instr    = Instr;
    fe_d.regwrite = RegWrite;
    fe_d.memwrite = MemWrite;
    fe_d.alusrc   = ALUSrc;
    fe_d.immsrc   = ImmSrc;
    fe_d.lm       = LM;
    fe_d.pcsrc    = PCSrc;
    fe_d.aluctl   = ALUControl;
    fe_d.valid    = 1'b1;
  end

  assign e_rd      = fe_q.instr[RD_LSB  +: REG_IDX_W];
  assign e_rs1     = fe_q.instr[RS1_LSB +: REG_IDX_W];
  assign e_rs2     = fe_q.instr[RS2_LSB +: REG_IDX_W];
  assign unused_hi = ^fe_q.instr[15:11];

  always_comb begin
    if (fe_q.immsrc) ext_imm = DW'($signed(fe_q.instr[IMM_S_W-1:0]));
    else             ext_imm = DW'(fe_q.instr[IMM_Z_W-1:0]);
  end

  // The instruction in W has not yet written the register file, so a
  // matching read takes its result directly; this covers load-use as well.
  assign src_a   = (w_valid && w_we && (w_rd == e_rs1)) ? w_res : rf[e_rs1];
  assign rs2_val = (w_valid && w_we && (w_rd == e_rs2)) ? w_res : rf[e_rs2];
  assign src_b   = fe_q.alusrc ? ext_imm : rs2_val;

  pipe_alu #(.DW(DW)) u_alu (
    .a      (src_a),
    .b      (src_b),
    .op     (fe_q.aluctl),
    .result (alu_res),
    .flags  (ALUFlags)
  );

  assign e_mem       = fe_q.lm | fe_q.memwrite;
  assign e_res       = fe_q.lm ? ReadData : alu_res;
  assign e_branch    = fe_q.valid & fe_q.pcsrc;
  assign WriteData   = rs2_val;
  assign DataAdr     = (e_mem && !reset) ? (src_a[AW-1:0] + fe_q.instr[AW-1:0]) : '0;
  assign MemWriteOut = fe_q.memwrite & fe_q.valid & ~Stall & ~reset;

  // PC, F/E and E/W registers. Stall outranks a branch in E, so a held
  // branch resolves on the first unstalled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC      <= '0;
      fe_q    <= '0;
      w_valid <= 1'b0;
      w_we    <= 1'b0;
      w_rd    <= '0;
      w_res   <= '0;
      Retired <= '0;
    end else begin
      if (w_valid) Retired <= Retired + 16'd1;
      if (Stall) begin
        w_valid <= 1'b0;
        w_we    <= 1'b0;
      end else begin
        w_valid <= fe_q.valid;
        w_we    <= fe_q.regwrite;
        w_rd    <= e_rd;
        w_res   <= e_res;
        if (e_branch) begin
          PC   <= fe_q.instr[AW-1:0];
          fe_q <= '0;
        end else begin
          PC   <= PC + AW'(PC_INC);
          fe_q <= fe_d;
        end
      end
    end
  end

  // Register file write happens on the edge that retires W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (w_valid && w_we) begin
      rf[w_rd] <= w_res;
    end
  end

endmodule

// File: tb/tb_pipe_datapath.sv
// Bench for pipe_datapath: directed programs plus randomized programs,
// checked against an instruction-level reference model. Stores are
// scoreboarded through exp_q; PC, Retired, flags and DataAdr are compared
// every cycle by the negedge monitor. The ALU is also checked at DW=16.
module tb_pipe_datapath;
  import pipe_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [15:0]   Instr;
  logic          RegWrite, MemWrite, ALUSrc, ImmSrc, LM, PCSrc, Stall;
  logic [4:0]    ALUControl;
  logic [DW-1:0] ReadData;
  logic [AW-1:0] PC, DataAdr;
  logic [DW-1:0] WriteData;
  logic          MemWriteOut;
  logic [3:0]    ALUFlags;
  logic [15:0]   Retired;

  pipe_datapath #(.DW(DW), .AW(AW), .PC_INC(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .LM(LM),
    .PCSrc(PCSrc), .ALUControl(ALUControl), .Stall(Stall),
    .ReadData(ReadData), .PC(PC), .DataAdr(DataAdr), .WriteData(WriteData),
    .MemWriteOut(MemWriteOut), .ALUFlags(ALUFlags), .Retired(Retired)
  );

  logic [15:0] a16, b16, r16;
  logic [4:0]  op16;
  logic [3:0]  f16;
  pipe_alu #(.DW(16)) u_alu16 (.a(a16), .b(b16), .op(op16), .result(r16), .flags(f16));

  typedef struct packed {
    logic [15:0] instr;
    logic rw, mw, alusrc, immsrc, lm, pcsrc;
    logic [4:0] aluc;
  } op_t;

  op_t            prog [256];
  logic [DW-1:0]  dmem [256];

  // reference model state (architectural view)
  logic [AW-1:0]  m_pc;
  logic           m_ev;
  op_t            m_e;
  logic [DW-1:0]  m_regs [8];
  logic [15:0]    m_ret;
  logic           m_wv;
  logic           mon_en;

  // scoreboard
  logic [AW+DW-1:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_alu(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic [3:0] f);
    int unsigned ua, ub;
    int sa, sb, s;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = 1'b0; v = 1'b0; r = 8'h00;
    case (op)
      5'd0: begin r = 8'(ua + ub); c = (ua + ub) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
      5'd1: begin r = 8'(ua - ub); c = (ua >= ub);      s = sa - sb; v = (s > 127) || (s < -128); end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = 8'(ua << b[2:0]);
      5'd6: r = a >> b[2:0];
      5'd7: r = b;
      default: r = 8'h00;
    endcase
    f = {r[7], (r == 8'h00), c, v};
  endfunction

  // Expected E-stage outputs for the instruction the model holds in E.
  function automatic void exp_e(output logic [7:0] adr, output logic [7:0] wd,
                                output logic [7:0] alur, output logic [3:0] flg);
    logic [7:0] a, b, imm;
    a   = m_regs[m_e.instr[5:3]];
    wd  = m_regs[m_e.instr[2:0]];
    imm = m_e.immsrc ? m_e.instr[7:0] : {5'b0, m_e.instr[2:0]};
    b   = m_e.alusrc ? imm : wd;
    ref_alu(m_e.aluc, a, b, alur, flg);
    adr = (m_e.lm || m_e.mw) ? 8'(a + m_e.instr[7:0]) : 8'h00;
  endfunction

  // driver: present the fetch at the model PC and the memory response
  task automatic drive(input logic st);
    logic [7:0] adr, wd, alur;
    logic [3:0] flg;
    Stall      = st;
    Instr      = prog[m_pc].instr;
    RegWrite   = prog[m_pc].rw;
    MemWrite   = prog[m_pc].mw;
    ALUSrc     = prog[m_pc].alusrc;
    ImmSrc     = prog[m_pc].immsrc;
    LM         = prog[m_pc].lm;
    PCSrc      = prog[m_pc].pcsrc;
    ALUControl = prog[m_pc].aluc;
    exp_e(adr, wd, alur, flg);
    ReadData = dmem[adr];
    if (m_ev && m_e.mw && !st) exp_q.push_back({adr, wd});
  endtask

  // advance one clock, updating the model at the edge
  task automatic tick();
    logic [7:0] adr, wd, alur;
    logic [3:0] flg;
    exp_e(adr, wd, alur, flg);
    @(posedge clk);
    if (m_wv) m_ret = m_ret + 16'd1;
    if (Stall) begin
      m_wv = 1'b0;
    end else begin
      if (m_ev && m_e.rw) m_regs[m_e.instr[10:8]] = m_e.lm ? ReadData : alur;
      m_wv = m_ev;
      if (m_ev && m_e.pcsrc) begin
        m_pc = m_e.instr[7:0];
        m_ev = 1'b0;
      end else begin
        m_e  = prog[m_pc];
        m_ev = 1'b1;
        m_pc = m_pc + 8'd4;
      end
    end
    #1;
  endtask

  task automatic step(input logic st);
    drive(st);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Stall = 1'b0;
    m_pc = '0; m_ev = 1'b0; m_wv = 1'b0; m_ret = '0; m_e = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    exp_q.delete();
    #1;
    chk("rst_memwrite", 32'(MemWriteOut), 32'd0);
    chk("rst_dataadr", 32'(DataAdr), 32'd0);
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_retired", 32'(Retired), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk("pc_after_release", 32'(PC), 32'd0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = '0;
  endtask

  function automatic op_t mk(input logic [15:0] ins, input logic rw, input logic mw,
                             input logic asrc, input logic isrc, input logic lm,
                             input logic pcs, input logic [4:0] aluc);
    op_t o;
    o = '{ins, rw, mw, asrc, isrc, lm, pcs, aluc};
    return o;
  endfunction

  // monitor: per-cycle comparisons and store scoreboard
  always @(negedge clk) begin
    logic [7:0] adr, wd, alur;
    logic [3:0] flg;
    logic [AW+DW-1:0] e;
    if (!reset && mon_en) begin
      exp_e(adr, wd, alur, flg);
      chk("pc", 32'(PC), 32'(m_pc));
      chk("retired", 32'(Retired), 32'(m_ret));
      if (m_ev) begin
        chk("alu_flags", 32'(ALUFlags), 32'(flg));
        chk("data_adr", 32'(DataAdr), 32'(adr));
      end
      if (MemWriteOut) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL store_unexpected: adr %0h data %0h expected none", DataAdr, WriteData);
        end else begin
          e = exp_q.pop_front();
          chk("store", 32'({DataAdr, WriteData}), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mon_en = 1'b0; Stall = 1'b0; Instr = '0;
    RegWrite = 0; MemWrite = 0; ALUSrc = 0; ImmSrc = 0; LM = 0; PCSrc = 0;
    ALUControl = '0; ReadData = '0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    clear_prog();

    // ALU at DW=16
    a16 = 16'h8000; b16 = 16'h0001; op16 = 5'd1; #1;
    chk("alu16_sub_res", 32'(r16), 32'h7FFF);
    chk("alu16_sub_flags", 32'(f16), 32'b0011);
    a16 = 16'hFFFF; b16 = 16'h0001; op16 = 5'd0; #1;
    chk("alu16_add_res", 32'(r16), 32'h0000);
    chk("alu16_add_flags", 32'(f16), 32'b0110);
    a16 = 16'h1234; b16 = 16'h5678; op16 = 5'd9; #1;
    chk("alu16_op9_res", 32'(r16), 32'h0000);
    chk("alu16_op9_flags", 32'(f16), 32'b0100);
    a16 = 16'h0001; b16 = 16'h000F; op16 = 5'd5; #1;
    chk("alu16_shl_res", 32'(r16), 32'h0080);
    a16 = 16'h0000; b16 = 16'h8001; op16 = 5'd7; #1;
    chk("alu16_pass_flags", 32'(f16), 32'b1000);

    mon_en = 1'b1;

    // straight-line: r1 = r0 + 3; r2 = r1 + r1; store r2
    clear_prog();
    prog[0] = mk(16'h0103, 1, 0, 1, 0, 0, 0, 5'd0);
    prog[4] = mk(16'h0209, 1, 0, 0, 0, 0, 0, 5'd0);
    prog[8] = mk(16'h0002, 0, 1, 0, 0, 0, 0, 5'd0);
    do_reset();
    repeat (3) step(1'b0);
    drive(1'b0); #1;
    chk("straight_r2", 32'(WriteData), 32'h06);
    tick();
    chk("straight_retired", 32'(Retired), 32'd2);
    repeat (4) step(1'b0);

    // load-use: r3 = mem[0x10]; r4 = r3 + r0; store r4
    clear_prog();
    dmem[8'h10] = 8'hA5;
    prog[0] = mk(16'h0310, 1, 0, 0, 0, 1, 0, 5'd0);
    prog[4] = mk(16'h0418, 1, 0, 0, 0, 0, 0, 5'd0);
    prog[8] = mk(16'h0004, 0, 1, 0, 0, 0, 0, 5'd0);
    do_reset();
    repeat (3) step(1'b0);
    drive(1'b0); #1;
    chk("loaduse_r4", 32'(WriteData), 32'hA5);
    chk("loaduse_adr", 32'(DataAdr), 32'h04);
    tick();
    repeat (4) step(1'b0);

    // taken branch to 0x40; the shadow instruction would store if executed
    clear_prog();
    prog[0] = mk(16'h0140, 1, 0, 0, 0, 0, 1, 5'd0);
    prog[4] = mk(16'h0200, 1, 1, 0, 0, 0, 0, 5'd0);
    do_reset();
    step(1'b0);
    step(1'b0);
    chk("branch_pc", 32'(PC), 32'h40);
    step(1'b0);
    step(1'b0);
    chk("branch_retired", 32'(Retired), 32'd1);
    repeat (3) step(1'b0);

    // branch (also a store) held by Stall for 3 cycles
    do_reset();
    prog[0] = mk(16'h0140, 1, 1, 0, 0, 0, 1, 5'd0);
    step(1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1); #1;
      chk("stall_memwrite", 32'(MemWriteOut), 32'd0);
      chk("stall_pc", 32'(PC), 32'h04);
      tick();
    end
    drive(1'b0); #1;
    chk("unstall_memwrite", 32'(MemWriteOut), 32'd1);
    tick();
    chk("unstall_pc", 32'(PC), 32'h40);
    repeat (3) step(1'b0);

    // reset with a store in E
    clear_prog();
    prog[0] = mk(16'h0137, 1, 0, 1, 1, 0, 0, 5'd0);
    prog[4] = mk(16'h050D, 1, 0, 1, 0, 0, 0, 5'd0);
    prog[8] = mk(16'h000D, 0, 1, 0, 0, 0, 0, 5'd0);
    do_reset();
    repeat (3) step(1'b0);
    drive(1'b0); #1;
    chk("pre_reset_memwrite", 32'(MemWriteOut), 32'd1);
    chk("pre_reset_data", 32'(WriteData), 32'h3C);
    clear_prog();
    for (int k = 0; k < 8; k++) prog[4*k] = mk(16'(k), 0, 1, 0, 0, 0, 0, 5'd0);
    do_reset();
    step(1'b0);
    drive(1'b0); #1;
    chk("post_reset_r0", 32'(WriteData), 32'h00);
    chk("post_reset_pc", 32'(PC), 32'h04);
    tick();
    repeat (9) step(1'b0);

    // randomized programs with random stalls
    for (int i = 0; i < 256; i++) begin
      prog[i].instr  = 16'($urandom);
      prog[i].rw     = 1'($urandom_range(0, 1));
      prog[i].mw     = ($urandom_range(0, 3) == 0);
      prog[i].lm     = !prog[i].mw && ($urandom_range(0, 3) == 0);
      prog[i].alusrc = 1'($urandom_range(0, 1));
      prog[i].immsrc = 1'($urandom_range(0, 1));
      prog[i].pcsrc  = ($urandom_range(0, 7) == 0);
      prog[i].aluc   = 5'($urandom_range(0, 11));
      dmem[i]        = 8'($urandom);
    end
    do_reset();
    for (int i = 0; i < 500; i++) step($urandom_range(0, 5) == 0);

    @(negedge clk);
    #1;
    chk("store_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
